// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller around the 8-bit ALU with an 8x8 register file and opcode legality check.
// Latency: legal op enables the ALU 1 cycle after accept and writes back 2 cycles after; illegal op reports in 1.
// Backpressure: in_ready is high only in IDLE; one legal op every 3 cycles, one illegal op every 2.
module alu_issue_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_op,
    input  logic [2:0] in_rd,
    input  logic [2:0] in_rs,
    input  logic [2:0] in_rt,
    input  logic       in_imm_en,
    input  logic [7:0] in_imm,
    input  logic       ext_wr_en,
    input  logic [2:0] ext_wr_addr,
    input  logic [7:0] ext_wr_data,
    input  logic [2:0] dbg_addr,
    output logic [7:0] dbg_data,
    output logic       alu_enable,
    output logic [7:0] alu_operation,
    output logic [7:0] alu_op1,
    output logic [7:0] alu_op2,
    output logic       alu_cpu_carry,
    input  logic [7:0] alu_result_l,
    input  logic [7:0] alu_result_h,
    input  logic       alu_carry,
    input  logic       alu_zero,
    input  logic       alu_sign,
    output logic [2:0] flags,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] rf [8];
    logic [2:0] rd_q;
    logic       mul_q;
    logic       op_single;
    logic       op_two;
    logic       op_mul;
    logic       op_legal;
    logic       accept;

    always_comb begin
        op_single = 1'b0;
        case (in_op)
            8'h01, 8'h02, 8'h03, 8'h06,
            8'h07, 8'h08, 8'h09, 8'h0A: op_single = 1'b1;
            default:                    op_single = 1'b0;
        endcase
    end

    // Two-operand opcodes ignore bit 0; bits [6:1] select ADD..XOR.
    assign op_two   = in_op[7] && (in_op[6:1] >= 6'd7) && (in_op[6:1] <= 6'd13);
    assign op_mul   = in_op[7] && ((in_op[6:1] == 6'd9) || (in_op[6:1] == 6'd10));
    assign op_legal = op_single || op_two;
    assign accept   = in_valid && (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = op_legal ? ISSUE : ERR;
            ISSUE:   state_nxt = WB;
            WB:      state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state == IDLE);
        alu_enable = (state == ISSUE);
        done       = (state == WB) || (state == ERR);
        err        = (state == ERR);
    end

    // Operands are captured from the pre-write register file, so a same-edge ext write is not seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_operation <= 8'h00;
            alu_op1       <= 8'h00;
            alu_op2       <= 8'h00;
            rd_q          <= 3'd0;
            mul_q         <= 1'b0;
        end else if (accept && op_legal) begin
            alu_operation <= in_op;
            alu_op1       <= rf[in_rs];
            alu_op2       <= op_single ? 8'h00 : (in_imm_en ? in_imm : rf[in_rt]);
            rd_q          <= in_rd;
            mul_q         <= op_mul;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= 3'b000;
        end else if (state == WB) begin
            flags <= {alu_sign, alu_zero, alu_carry};
        end
    end

    // High half of a multiply lands in rd+1, wrapping r7 onto r0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                rf[i] <= 8'h00;
            end
        end else begin
            if ((state == IDLE) && ext_wr_en) begin
                rf[ext_wr_addr] <= ext_wr_data;
            end
            if (state == WB) begin
                rf[rd_q] <= alu_result_l;
                if (mul_q) begin
                    rf[rd_q + 3'd1] <= alu_result_h;
                end
            end
        end
    end

    assign dbg_data      = rf[dbg_addr];
    assign alu_cpu_carry = flags[0];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboarded random and directed bench for alu_issue_ctrl; the bench plays the ALU.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_op = 8'h00;
    logic [2:0] in_rd = 3'd0, in_rs = 3'd0, in_rt = 3'd0;
    logic       in_imm_en = 1'b0;
    logic [7:0] in_imm = 8'h00;
    logic       ext_wr_en = 1'b0;
    logic [2:0] ext_wr_addr = 3'd0;
    logic [7:0] ext_wr_data = 8'h00;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;
    logic       alu_enable;
    logic [7:0] alu_operation, alu_op1, alu_op2;
    logic       alu_cpu_carry;
    logic [7:0] alu_result_l = 8'h00, alu_result_h = 8'h00;
    logic       alu_carry = 1'b0, alu_zero = 1'b0, alu_sign = 1'b0;
    logic [2:0] flags;
    logic       done, err;

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
        .in_imm_en(in_imm_en), .in_imm(in_imm),
        .ext_wr_en(ext_wr_en), .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .alu_enable(alu_enable), .alu_operation(alu_operation),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_cpu_carry(alu_cpu_carry),
        .alu_result_l(alu_result_l), .alu_result_h(alu_result_h),
        .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_sign(alu_sign),
        .flags(flags), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] op, op1, op2;
        bit         cin;
        int         acc_cyc;
        logic [2:0] rd;
        bit         mul;
        logic [7:0] rl, rh;
        logic [2:0] fl;
    } item_t;

    item_t iss_q[$];
    item_t done_q[$];

    logic [7:0] mreg [8];
    logic [2:0] mflags;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_fail = 0;
    logic [2:0] mon_addr = 3'd0;
    logic [2:0] main_addr = 3'd0;
    bit         mon_active = 1'b0;
    int         stage = 0;

    logic [7:0] legal_ops [22] = '{8'h01, 8'h02, 8'h03, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A,
                                   8'h8E, 8'h8F, 8'h90, 8'h91, 8'h92, 8'h93, 8'h94,
                                   8'h95, 8'h96, 8'h97, 8'h98, 8'h99, 8'h9A, 8'h9B};

    assign dbg_addr = (mon_active && !rst) ? mon_addr : main_addr;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit m_single(input logic [7:0] op);
        return op inside {8'h01, 8'h02, 8'h03, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    endfunction

    function automatic bit m_legal(input logic [7:0] op);
        return m_single(op) || (op inside {[8'h8E:8'h9B]});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
        mflags = 3'b000;
        iss_q.delete();
        done_q.delete();
    endtask

    // Offer one instruction (optionally with an ext write) and update the reference model on accept.
    task automatic issue(input logic [7:0] op, input logic [2:0] rd, rs, rt,
                         input bit ie, input logic [7:0] imm,
                         input bit xe, input logic [2:0] xa, input logic [7:0] xd,
                         input logic [7:0] rl, rh, input bit c, z, s, output int acc);
        item_t e;
        int    n;
        @(negedge clk);
        in_op = op; in_rd = rd; in_rs = rs; in_rt = rt;
        in_imm_en = ie; in_imm = imm; in_valid = 1'b1;
        ext_wr_en = xe; ext_wr_addr = xa; ext_wr_data = xd;
        n = 0;
        while (!in_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            ext_wr_en = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        ext_wr_en = 1'b0;
        alu_result_l = rl; alu_result_h = rh;
        alu_carry = c; alu_zero = z; alu_sign = s;
        e.is_err  = !m_legal(op);
        e.op      = op;
        e.op1     = mreg[rs];
        e.op2     = m_single(op) ? 8'h00 : (ie ? imm : mreg[rt]);
        e.cin     = mflags[0];
        e.acc_cyc = acc;
        e.rd      = rd;
        e.mul     = op inside {[8'h92:8'h95]};
        e.rl      = rl;
        e.rh      = rh;
        if (xe) mreg[xa] = xd;
        if (!e.is_err) begin
            mreg[rd] = rl;
            if (e.mul) mreg[(rd + 1) % 8] = rh;
            mflags = {s, z, c};
            iss_q.push_back(e);
        end
        e.fl = mflags;
        done_q.push_back(e);
    endtask

    task automatic gap(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        ext_wr_en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic ext_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        in_valid = 1'b0;
        if (!in_ready) chk("ext_write_not_idle", 32'd0, 32'd1);
        ext_wr_en = 1'b1; ext_wr_addr = a; ext_wr_data = d;
        @(posedge clk);
        #1;
        ext_wr_en = 1'b0;
        mreg[a] = d;
    endtask

    task automatic sweep(input string name);
        for (int a = 0; a < 8; a++) begin
            main_addr = a[2:0];
            #1;
            chk(name, dbg_data, mreg[a]);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((iss_q.size() != 0 || done_q.size() != 0 || stage != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", n < 50, 1);
        @(negedge clk);
    endtask

    // Monitor: pops expectations whenever the DUT enables the ALU or pulses done.
    item_t ei, cur;
    always @(negedge clk) begin
        if (rst) begin
            stage = 0;
            mon_active = 1'b0;
        end else begin
            if (alu_enable) begin
                if (iss_q.size() == 0) begin
                    chk("unexpected_alu_enable", 32'd1, 32'd0);
                end else begin
                    ei = iss_q.pop_front();
                    chk("alu_operation", alu_operation, ei.op);
                    chk("alu_op1", alu_op1, ei.op1);
                    chk("alu_op2", alu_op2, ei.op2);
                    chk("alu_cpu_carry", alu_cpu_carry, ei.cin);
                    chk("enable_cycle", cyc, ei.acc_cyc);
                end
            end
            if (stage == 1) begin
                chk("wb_flags", flags, cur.fl);
                chk("wb_rd", dbg_data, cur.rl);
                if (cur.mul) begin
                    mon_addr = cur.rd + 3'd1;
                    stage = 2;
                end else begin
                    stage = 0;
                    mon_active = 1'b0;
                end
            end else if (stage == 2) begin
                chk("wb_rd_plus1", dbg_data, cur.rh);
                stage = 0;
                mon_active = 1'b0;
            end else if (stage == 3) begin
                chk("err_flags_kept", flags, cur.fl);
                stage = 0;
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    cur = done_q.pop_front();
                    chk("err_pulse", err, cur.is_err);
                    chk("done_cycle", cyc, cur.is_err ? cur.acc_cyc : cur.acc_cyc + 1);
                    if (cur.is_err) begin
                        stage = 3;
                    end else begin
                        mon_addr = cur.rd;
                        mon_active = 1'b1;
                        stage = 1;
                    end
                end
            end
        end
    end

    int         acc1, acc2;
    logic [7:0] rop;
    bit         rmul;

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_flags", flags, 3'b000);
        chk("reset_alu_enable", alu_enable, 0);
        chk("reset_done_err", {done, err}, 2'b00);
        sweep("reset_regs");

        // ADD r3 = r1 + r2
        ext_write(3'd1, 8'h0F);
        ext_write(3'd2, 8'h03);
        issue(8'h8E, 3'd3, 3'd1, 3'd2, 0, 8'h00, 0, 3'd0, 8'h00, 8'h12, 8'h00, 0, 0, 0, acc1);
        gap(3);

        // MUL with rd=7 wraps the high byte into r0
        ext_write(3'd1, 8'h10);
        ext_write(3'd2, 8'h20);
        issue(8'h92, 3'd7, 3'd1, 3'd2, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 8'h02, 0, 0, 0, acc1);
        gap(3);
        sweep("mul_wrap_regs");

        // INC ignores the immediate; its carry feeds the following RLC
        ext_write(3'd4, 8'hFF);
        issue(8'h02, 3'd5, 3'd4, 3'd0, 1, 8'h55, 0, 3'd0, 8'h00, 8'h00, 8'h00, 1, 1, 0, acc1);
        gap(2);
        chk("inc_flags", flags, 3'b011);
        issue(8'h08, 3'd6, 3'd5, 3'd0, 0, 8'h00, 0, 3'd0, 8'h00, 8'h01, 8'h00, 0, 0, 0, acc1);
        gap(3);

        // Illegal opcode followed by a held-valid ADD
        issue(8'h05, 3'd2, 3'd1, 3'd1, 0, 8'h00, 0, 3'd0, 8'h00, 8'hEE, 8'hEE, 1, 1, 1, acc1);
        issue(8'h8E, 3'd2, 3'd1, 3'd1, 0, 8'h00, 0, 3'd0, 8'h00, 8'h20, 8'h00, 0, 0, 1, acc2);
        chk("illegal_reaccept_gap", acc2 - acc1, 2);
        gap(3);

        for (int k = 0; k < 250; k++) begin
            if ($urandom_range(0, 3) == 0) rop = $urandom_range(0, 255);
            else rop = legal_ops[$urandom_range(0, 21)];
            rmul = rop inside {[8'h92:8'h95]};
            issue(rop, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 255),
                  $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255),
                  $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), acc1);
            if (rmul) gap(2 + $urandom_range(0, 1));
            else if ($urandom_range(0, 1) == 1) gap($urandom_range(0, 2));
        end
        gap(1);
        drain();
        sweep("random_final_regs");
        chk("random_final_flags", flags, mflags);

        // Reset mid-run, during writeback
        issue(8'h96, 3'd1, 3'd2, 3'd3, 0, 8'h00, 0, 3'd0, 8'h00, 8'h77, 8'h00, 1, 0, 1, acc1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("midrun_in_ready", in_ready, 1);
        chk("midrun_flags", flags, 3'b000);
        chk("midrun_alu_enable", alu_enable, 0);
        sweep("midrun_regs");
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        sweep("midrun_regs_after");

        // Reset while the ALU is enabled
        ext_write(3'd1, 8'h40);
        issue(8'h8E, 3'd6, 3'd1, 3'd1, 0, 8'h00, 0, 3'd0, 8'h00, 8'h80, 8'h00, 0, 0, 1, acc1);
        chk("issue_enable_high", alu_enable, 1);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_enable_drop", alu_enable, 0);
        chk("rst_done_err", {done, err}, 2'b00);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_done", done, 0);
        end
        sweep("rst_issue_regs");
        chk("rst_issue_in_ready", in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got %0d cycles expected fewer", cyc);
        $fatal(1, "timeout");
    end

endmodule
